// File: rtl/reg_list_seq.sv
// reg_list_seq -- register-list transfer sequencer.
//
// On an accepted start, latches a register list and base address, then
// issues one beat per set list bit (lowest index first) with an
// incrementing word address, handshaked by xfer_valid_o/xfer_ready_i.
// A one-cycle done_o pulse follows the last beat (or the start edge
// directly for an empty list).
//
// Optional feature macro: REG_LIST_DESC_EN
//   defined   -> desc_i present; desc_i=1 starts at base-count and
//                writes back base-count (register order still ascending)
//   undefined -> ascending only, no subtractor in the address path
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   start_i       begin a transfer (sampled in IDLE only)
//   list_i        register list, bit n = transfer register n
//   base_i        base address
//   desc_i        descending mode (REG_LIST_DESC_EN only)
//   busy_o        not in IDLE
//   xfer_valid_o  beat presented (RUN only)
//   xfer_ready_i  consumer accepts the beat
//   reg_idx_o     register index of current beat
//   addr_o        word address of current beat
//   last_o        current beat is the final one
//   done_o        one-cycle completion pulse
//   count_o       byte count = popcount(list) * 4
//   wb_addr_o     base-register writeback value
module reg_list_seq #(
  parameter int unsigned LIST_W = 10,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [LIST_W-1:0] list_i,
  input  logic [31:0]       base_i,
`ifdef REG_LIST_DESC_EN
  input  logic              desc_i,
`endif
  output logic              busy_o,
  output logic              xfer_valid_o,
  input  logic              xfer_ready_i,
  output logic [IDX_W-1:0]  reg_idx_o,
  output logic [31:0]       addr_o,
  output logic              last_o,
  output logic              done_o,
  output logic [31:0]       count_o,
  output logic [31:0]       wb_addr_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LIST_W-1:0] r_list;
  logic [31:0]       r_addr;
  logic [31:0]       r_count;
  logic [31:0]       r_wb_addr;

  logic [31:0]       w_count;
  logic [31:0]       w_start_addr;
  logic [31:0]       w_wb_addr;
  logic [LIST_W-1:0] w_low_onehot;
  logic [IDX_W-1:0]  w_low_idx;
  logic [LIST_W-1:0] w_list_rest;
  logic              w_start;
  logic              w_accept;
  logic              w_last;

  // Byte count of the incoming list.
  always_comb begin
    w_count = '0;
    for (int unsigned i = 0; i < LIST_W; i++) begin
      w_count = w_count + {29'd0, list_i[i], 2'b00};
    end
  end

`ifdef REG_LIST_DESC_EN
  logic [31:0] w_low_addr;
  assign w_low_addr   = base_i - w_count;
  assign w_start_addr = desc_i ? w_low_addr : base_i;
  assign w_wb_addr    = desc_i ? w_low_addr : (base_i + w_count);
`else
  assign w_start_addr = base_i;
  assign w_wb_addr    = base_i + w_count;
`endif

  // Lowest set bit of the remaining list. Scanning high-to-low lets the
  // lowest hit overwrite any higher one.
  always_comb begin
    w_low_onehot = '0;
    w_low_idx    = '0;
    for (int unsigned i = LIST_W; i > 0; i--) begin
      if (r_list[i-1]) begin
        w_low_onehot        = '0;
        w_low_onehot[i-1]   = 1'b1;
        w_low_idx           = IDX_W'(i - 1);
      end
    end
  end

  // Clearing the one-hot avoids an r_list-1 subtractor.
  assign w_list_rest = r_list & ~w_low_onehot;
  assign w_start     = (r_state == S_IDLE) && start_i;
  assign w_last      = (r_state == S_RUN) && (w_list_rest == '0);
  assign w_accept    = (r_state == S_RUN) && xfer_ready_i;

  always_comb begin
    w_state_nxt  = r_state;
    busy_o       = 1'b0;
    xfer_valid_o = 1'b0;
    last_o       = 1'b0;
    done_o       = 1'b0;
    reg_idx_o    = w_low_idx;
    addr_o       = r_addr;
    count_o      = r_count;
    wb_addr_o    = r_wb_addr;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = (list_i != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        busy_o       = 1'b1;
        xfer_valid_o = 1'b1;
        last_o       = w_last;
        if (xfer_ready_i && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy_o      = 1'b1;
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_list    <= '0;
      r_addr    <= '0;
      r_count   <= '0;
      r_wb_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_list    <= list_i;
        r_addr    <= w_start_addr;
        r_count   <= w_count;
        r_wb_addr <= w_wb_addr;
      end else if (w_accept) begin
        r_list <= w_list_rest;
        r_addr <= r_addr + 32'd4;
      end
    end
  end

endmodule

// File: doc/reg_list_seq.md
REG_LIST_SEQ -- requirements
Module: reg_list_seq

Interface
REQ-001 SHALL have parameter LIST_W, default 10: register-list width, range 2..16.
REQ-002 SHALL have parameter IDX_W, default 4: register-index width, at least clog2(LIST_W).
REQ-003 SHALL have one clock and an asynchronous active-low reset; every port is listed below, clock and reset first.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start_i, input, 1 bit: request to begin a list transfer.
REQ-007 SHALL have port list_i, input, LIST_W bits: register list; bit n set means register n is transferred.
REQ-008 SHALL have port base_i, input, 32 bits: base address.
REQ-009 SHALL have port desc_i, input, 1 bit: descending (decrement-before) mode; present only with REG_LIST_DESC_EN.
REQ-010 SHALL have port busy_o, output, 1 bit: block is not in IDLE.
REQ-011 SHALL have port xfer_valid_o, output, 1 bit: a transfer beat is presented.
REQ-012 SHALL have port xfer_ready_i, input, 1 bit: consumer accepts the beat.
REQ-013 SHALL have port reg_idx_o, output, IDX_W bits: register index of the current beat.
REQ-014 SHALL have port addr_o, output, 32 bits: word address of the current beat.
REQ-015 SHALL have port last_o, output, 1 bit: the current beat is the final one.
REQ-016 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-017 SHALL have port count_o, output, 32 bits: total byte count, popcount(list) x 4.
REQ-018 SHALL have port wb_addr_o, output, 32 bits: base-register writeback value.

Function
REQ-019 SHALL implement states IDLE, RUN and DONE.
REQ-020 SHALL, in IDLE with start_i=1, latch list_i, base_i and desc_i into internal registers on that clock edge.
REQ-021 SHALL move from IDLE to RUN when the latched list is non-zero, and to DONE when it is zero; no beat is issued for a zero list.
REQ-022 SHALL ignore start_i in RUN and DONE.
REQ-023 SHALL update count_o and wb_addr_o on the start edge and hold them until the next accepted start.
REQ-024 SHALL compute count_o as the popcount of the latched list shifted left by 2, zero-extended to 32 bits.
REQ-025 SHALL assert xfer_valid_o in RUN only.
REQ-026 SHALL drive reg_idx_o with the lowest set bit of the remaining list.
REQ-027 SHALL drive addr_o with the current address.
REQ-028 SHALL hold reg_idx_o, addr_o and last_o stable while xfer_valid_o=1 and xfer_ready_i=0.
REQ-029 SHALL, on xfer_valid_o and xfer_ready_i both high, clear that bit from the remaining list and add 4 to the current address (modulo 2^32).
REQ-030 SHALL assert last_o while exactly one bit remains.
REQ-031 SHALL go to DONE on the accepted beat that has last_o=1; a list of one bit gives one beat with last_o=1.
REQ-032 SHALL drive done_o=1 for exactly one cycle in DONE, then return to IDLE.
REQ-033 SHALL accept start_i again in the cycle after DONE.
REQ-034 SHALL, in ascending mode, start at current address = base_i and set wb_addr_o = base_i + count.
REQ-035 SHALL perform all address arithmetic modulo 2^32, with wrap-around permitted.
REQ-036 SHALL give a throughput of one beat per cycle while xfer_ready_i is held high.
REQ-037 SHALL give latency start to first xfer_valid_o of one cycle.

Reset
REQ-038 SHALL, on rst_n low at any time including mid-list, force IDLE asynchronously and abandon the remaining beats.
REQ-039 SHALL hold these output values during reset: busy_o, xfer_valid_o, last_o and done_o = 0; reg_idx_o, addr_o, count_o and wb_addr_o = 0.
REQ-040 SHALL release from reset into IDLE, with no done_o pulse for an abandoned list.

Configuration
REQ-041 SHALL, with REG_LIST_DESC_EN defined, provide desc_i.
REQ-042 SHALL, with desc_i=1 at start, set the start address to base_i - count, keep register order ascending, and set wb_addr_o = base_i - count.
REQ-043 SHALL, with REG_LIST_DESC_EN undefined, omit desc_i, make operation ascending only, and contain no subtractor logic.

Verification
REQ-044 SHALL be checked with: list=10'b00_1000_0101, base=0x1000, ready held 1 -> beats (0,0x1000), (2,0x1004), (7,0x1008 with last); count_o=12; wb_addr_o=0x100C; done_o 1 cycle later.
REQ-045 SHALL be checked with: list=0, start -> no xfer_valid_o; done_o one cycle after IDLE; count_o=0; wb_addr_o=base.
REQ-046 SHALL be checked with: list=10'h3FF, ready toggling 1010... -> 10 beats, indices 0..9, outputs stable during stalls, count_o=40.
REQ-047 SHALL be checked with: base=0xFFFFFFFC, list=10'b11 -> addresses 0xFFFFFFFC then 0x00000000; wb_addr_o=0x4.
REQ-048 SHALL be checked with: rst_n pulsed low after the 2nd of 5 beats -> outputs at reset values immediately; no done_o; new start behaves normally.
REQ-049 SHALL be checked, with REG_LIST_DESC_EN defined, with: desc_i=1, base=0x2000, list=10'b0110 -> beats (1,0x1FF8), (2,0x1FFC); wb_addr_o=0x1FF8.
